// File: rtl/matrix_loader_if.sv
// Element-stream / matrix-bus bundle for matrix_loader.
// The slave modport is the loader; master is whoever feeds it and takes the matrix.
interface matrix_loader_if #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
);
  logic [2:0]                  size;
  logic [ELEM_W-1:0]           in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [DIM*DIM*ELEM_W-1:0]   matrix_out;
  logic                        out_valid;
  logic                        out_ready;
  logic                        size_err;

  modport master (
    output size, in_data, in_valid, out_ready,
    input  in_ready, matrix_out, out_valid, size_err
  );

  modport slave (
    input  size, in_data, in_valid, out_ready,
    output in_ready, matrix_out, out_valid, size_err
  );
endinterface

// File: rtl/matrix_loader.sv
// Assembles a streamed NxN matrix (N<=DIM) into the zero-padded DIM x DIM operator bus.
// Define MATRIX_LOADER_COL_MAJOR_EN to interpret the stream column-major.
module matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic            clk,
  input  logic            rst,
  matrix_loader_if.slave  bus
);
  localparam int CW = $clog2(DIM);
  localparam int NE = DIM * DIM;
  localparam int IW = $clog2(NE);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                     state, state_nx;
  logic [2:0]                 n_q, n_nx;
  logic [CW-1:0]              fast_q, fast_nx, slow_q, slow_nx;
  logic [CW-1:0]              row, col;
  logic [IW-1:0]              idx;
  logic [NE-1:0][ELEM_W-1:0]  mat, mat_nx;
  logic                       rdy_q, vld_q, err_q, err_nx;
  logic                       accept, size_bad;
  logic [2:0]                 size_c;

  // The fast counter walks along a row (row-major) or down a column (column-major).
`ifdef MATRIX_LOADER_COL_MAJOR_EN
  assign row = fast_q;
  assign col = slow_q;
`else
  assign row = slow_q;
  assign col = fast_q;
`endif

  assign idx      = IW'(row) * IW'(DIM) + IW'(col);
  assign accept   = bus.in_valid & rdy_q;
  assign size_bad = (bus.size == 3'd0) || (bus.size > 3'(DIM));
  assign size_c   = size_bad ? 3'(DIM) : bus.size;

  always_comb begin
    state_nx = state;
    n_nx     = n_q;
    fast_nx  = fast_q;
    slow_nx  = slow_q;
    mat_nx   = mat;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          n_nx      = size_c;
          err_nx    = size_bad;
          mat_nx    = '0;
          mat_nx[0] = bus.in_data;
          fast_nx   = CW'(1);
          slow_nx   = '0;
          state_nx  = (size_c == 3'd1) ? FULL : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          mat_nx[idx] = bus.in_data;
          if (fast_q == CW'(n_q - 3'd1)) begin
            fast_nx = '0;
            slow_nx = slow_q + CW'(1);
            if (slow_q == CW'(n_q - 3'd1)) state_nx = FULL;
          end else begin
            fast_nx = fast_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state, so out_ready
  // never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n_q    <= '0;
      fast_q <= '0;
      slow_q <= '0;
      mat    <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      n_q    <= n_nx;
      fast_q <= fast_nx;
      slow_q <= slow_nx;
      mat    <= mat_nx;
      rdy_q  <= (state_nx != FULL);
      vld_q  <= (state_nx == FULL);
      err_q  <= err_nx;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = vld_q;
  assign bus.matrix_out = mat;
  assign bus.size_err   = err_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: latency, placement, backpressure, size clamp, reset.
// Honours MATRIX_LOADER_COL_MAJOR_EN for stream ordering expectations.
module tb_matrix_loader;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  matrix_loader_if #(.ELEM_W(8), .DIM(5)) bus ();
  matrix_loader #(.ELEM_W(8), .DIM(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected bus for an n x n matrix whose k-th streamed element is v0+k.
  function automatic logic [199:0] expm(input int n, input int v0);
    logic [199:0] m;
    int r, c;
    m = '0;
    for (int k = 0; k < n * n; k++) begin
`ifdef MATRIX_LOADER_COL_MAJOR_EN
      r = k % n; c = k / n;
`else
      r = k / n; c = k % n;
`endif
      m[r*40 + c*8 +: 8] = 8'(v0 + k);
    end
    return m;
  endfunction

  // Present one element and return #1 after the edge on which it was accepted.
  task automatic send(input logic [7:0] d, input logic [2:0] sz);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.size     = sz;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [199:0] snap, e;
  logic         flag;
  int           c0;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.size = 3'd3; bus.out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_matrix", bus.matrix_out, '0);
    chk("rst_size_err", bus.size_err, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // 3x3, elements 1..9, gap-free
    bus.out_ready = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 9; k++) begin
      send(8'(k + 1), 3'd3);
      if (k == 7) chk("3x3_not_early", bus.out_valid, 1'b0);
    end
    chk("3x3_latency", 200'(cyc - c0), 200'd9);
    chk("3x3_out_valid", bus.out_valid, 1'b1);
    chk("3x3_in_ready_low", bus.in_ready, 1'b0);
    chk("3x3_b00", bus.matrix_out[0 +: 8], 8'd1);
`ifdef MATRIX_LOADER_COL_MAJOR_EN
    chk("3x3_b10", bus.matrix_out[40 +: 8], 8'd2);
    chk("3x3_b01", bus.matrix_out[8 +: 8], 8'd4);
`else
    chk("3x3_b02", bus.matrix_out[16 +: 8], 8'd3);
    chk("3x3_b10", bus.matrix_out[40 +: 8], 8'd4);
`endif
    chk("3x3_b22", bus.matrix_out[96 +: 8], 8'd9);
    chk("3x3_full", bus.matrix_out, expm(3, 1));
    snap = bus.matrix_out;
    step();
    chk("3x3_release_valid", bus.out_valid, 1'b0);
    chk("3x3_release_ready", bus.in_ready, 1'b1);
    chk("3x3_hold_after_release", bus.matrix_out, snap);

    // 5x5 with a bubble after every element
    flag = 1'b0;
    for (int k = 0; k < 25; k++) begin
      send(8'(k + 1), 3'd5);
      if (k < 24) begin
        flag |= bus.out_valid;
        step();
        flag |= bus.out_valid;
      end
    end
    chk("5x5_no_early_valid", flag, 1'b0);
    chk("5x5_out_valid", bus.out_valid, 1'b1);
    chk("5x5_matrix", bus.matrix_out, expm(5, 1));
`ifndef MATRIX_LOADER_COL_MAJOR_EN
    chk("5x5_k13", bus.matrix_out[13*8 +: 8], 8'd14);
`endif
    step();
    chk("5x5_single_pulse", bus.out_valid, 1'b0);

    // 2x2 with 10 cycles of backpressure
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(8'(k + 7), 3'd2);
    e = '0;
    e[0 +: 8] = 8'd7; e[48 +: 8] = 8'd10;
`ifdef MATRIX_LOADER_COL_MAJOR_EN
    e[40 +: 8] = 8'd8; e[8 +: 8] = 8'd9;
`else
    e[8 +: 8] = 8'd8; e[40 +: 8] = 8'd9;
`endif
    chk("2x2_matrix", bus.matrix_out, e);
    chk("2x2_out_valid", bus.out_valid, 1'b1);
    snap = bus.matrix_out;
    flag = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.matrix_out !== snap || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) flag = 1'b1;
    end
    chk("2x2_stall_stable", flag, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("2x2_release_ready", bus.in_ready, 1'b1);
    chk("2x2_release_valid", bus.out_valid, 1'b0);
    send(8'h55, 3'd1);
    chk("1x1_out_valid", bus.out_valid, 1'b1);
    chk("1x1_no_stale", bus.matrix_out, 200'h55);
    step();

    // size=6 clamps to 5; later size changes are ignored
    send(8'h80, 3'd6);
    chk("size6_err_pulse", bus.size_err, 1'b1);
    send(8'h81, 3'd2);
    chk("size6_err_once", bus.size_err, 1'b0);
    for (int k = 2; k < 24; k++) send(8'(8'h80 + k), 3'd2);
    chk("size6_not_early", bus.out_valid, 1'b0);
    send(8'h98, 3'd2);
    chk("size6_out_valid", bus.out_valid, 1'b1);
    chk("size6_matrix", bus.matrix_out, expm(5, 8'h80));
    step();

    // reset mid-matrix
    for (int k = 0; k < 4; k++) send(8'(k + 1), 3'd3);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_matrix", bus.matrix_out, '0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    step();
    for (int k = 0; k < 9; k++) send(8'(k + 11), 3'd3);
    chk("reload_out_valid", bus.out_valid, 1'b1);
    chk("reload_matrix", bus.matrix_out, expm(3, 11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream stage of the 3x3 determinant unit and the other matrix operators: accepts matrix elements one at a time over an 8-bit valid/ready stream and assembles them into the 200-bit linearized 5x5 matrix bus those operators consume. Element (i,j) sits at bits [i*40 + j*8 +: 8]. Matrices smaller than 5x5 are zero-padded, so a 3x3 occupies rows/cols 0..2. The assembled matrix is held stable with out_valid until the downstream operator takes it.

## Interface

- ELEM_W, 8, element width in bits; must stay 8 to match the operator bus
- DIM, 5, maximum matrix dimension; output width is DIM*DIM*ELEM_W = 200
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- size  input  3  matrix dimension N, sampled on the first accepted element of each matrix
- in_data  input  8  element value, row-major order
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept an element this cycle
- matrix_out  output  200  assembled matrix, element (i,j) at [i*40 + j*8 +: 8]
- out_valid  output  1  matrix_out complete and stable
- out_ready  input  1  downstream consumes matrix_out
- size_err  output  1  one-cycle pulse: sampled size was 0, 6 or 7

## Operation

- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- FSM states IDLE, LOAD, FULL.
- IDLE: in_ready=1. On accept: latch N = size (0, 6, 7 are clamped to 5, with size_err pulsed the next cycle); clear matrix_out to zero; write the element to (0,0); row=0, col=1. If N=1, go to FULL; otherwise go to LOAD.
- LOAD: in_ready=1. On each accept, write to (row,col) and advance: col+1; when col reaches N-1, col wraps to 0 and row increments. After the N*N-th accept, go to FULL. in_valid low inserts a bubble, and the counters hold.
- FULL: in_ready=0, out_valid=1, matrix_out is frozen. On release, go to IDLE. in_valid is ignored.
- Elements outside the N x N region stay 0 for the whole matrix.
- Change of size mid-matrix: ignored; the N latched at the first element governs.
- Reset in any state: discards the partial matrix and returns to IDLE with the reset values below.

## Timing

- Reset values: in_ready=0 in the cycle rst is high, then 1 from the first cycle after; out_valid=0, matrix_out=0, size_err=0, state IDLE, row=col=0.
- in_ready and out_valid are registered-state decodes. There is no combinational path from out_ready to in_ready.
- Latency: out_valid rises in the cycle after the N*N-th accept, so a gap-free NxN matrix gives out_valid N*N cycles after the first accept.
- Release: out_valid falls and in_ready rises in the cycle after release. Minimum matrix period is N*N+1 cycles with out_ready tied high.
- matrix_out updates only on accept edges and holds its value in FULL and after release until the next first accept.
- size_err is asserted in the cycle after the offending first accept, for exactly one cycle.

## Configuration

- MATRIX_LOADER_COL_MAJOR_EN defined: the stream is interpreted column-major. Successive elements fill (0,0), (1,0), … (N-1,0), (0,1), …, so the row counter is the fast one. Bit placement of matrix_out is unchanged.
- Not defined: row-major as described above.

## Test plan

- Reset, then stream 3x3 elements 1..9 gap-free with out_ready=1 -> out_valid high 9 cycles after the first accept. Bytes at (0,0)=1, (0,2)=3, (1,0)=4, (2,2)=9; all other 16 bytes are 0. Feeding this to the determinant unit gives result 0.
- size=5, stream 25 elements with in_valid toggling every other cycle -> element k lands at bits [k*8 +: 8]. out_valid rises once, after the 25th accept.
- Complete a 2x2 (elements 7,8,9,10) with out_ready held low for 10 cycles -> in_ready=0 and matrix_out stable throughout. After release, in_ready=1 the next cycle, and a new matrix loads with no stale nonzero bytes.
- size=6 on the first element -> size_err pulses once. The loader expects 25 elements and pads nothing.
- Assert rst after 4 of 9 elements -> the next cycle shows out_valid=0, matrix_out=0, in_ready=0. A fresh 9-element load then completes correctly.
- With MATRIX_LOADER_COL_MAJOR_EN, stream 3x3 elements 1..9 -> (1,0)=2, (0,1)=4, (2,2)=9.
